pulse_tx_sequencer: RTL and testbench

PULSE_TX_SEQUENCER -- requirements
Module: pulse_tx_sequencer

---
 rtl/pulse_tx_pkg.sv | 16 +
 rtl/pulse_tx_prescaler.sv | 32 +++
 rtl/pulse_tx_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pulse_tx_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_tx_pkg.sv
// Shared types and constants for the pulse transmit sequencer.
// The symbol word is {level, duration}; the level bit sits directly above the duration field.
package pulse_tx_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int DEF_SYM_DEPTH = 8;
  localparam int DEF_DUR_W     = 7;
  localparam int DUR_LSB       = 0;
  localparam int LOOP_W        = 8;
  localparam int PRE_W         = 4;

endpackage

// File: rtl/pulse_tx_prescaler.sv
// Tick generator: one-cycle tick every prescale+1 cycles while enabled.
// The period is captured on clear, which also restarts the count.
module pulse_tx_prescaler
  import pulse_tx_pkg::*;
(
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] period;
  logic [PRE_W-1:0] cnt;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period <= '0;
      cnt    <= '0;
    end else if (clear) begin
      period <= prescale;
      cnt    <= prescale;
    end else if (enable) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/pulse_tx_sequencer.sv
// Pulse transmit sequencer: plays symbols 0..last_idx for loop_count+1 passes.
// Define PULSE_TX_CARRIER_EN to add carrier_div and modulate level-1 symbols with a carrier.
//
//   state  | meaning
//   S_IDLE | pulse_out follows idle_level, waiting for start
//   S_RUN  | playing the symbol table, busy high
module pulse_tx_sequencer
  import pulse_tx_pkg::*;
#(
  parameter int SYM_DEPTH = DEF_SYM_DEPTH,
  parameter int DUR_W     = DEF_DUR_W
) (
  input  logic                         clk,
  input  logic                         sys_rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(SYM_DEPTH)-1:0] wr_addr,
  input  logic [DUR_W:0]               wr_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic [$clog2(SYM_DEPTH)-1:0] last_idx,
  input  logic [LOOP_W-1:0]            loop_count,
  input  logic [PRE_W-1:0]             prescale,
  input  logic                         idle_level,
`ifdef PULSE_TX_CARRIER_EN
  input  logic [7:0]                   carrier_div,
`endif
  output logic                         pulse_out,
  output logic                         busy,
  output logic                         done_pulse
);

  localparam int AW      = $clog2(SYM_DEPTH);
  localparam int LVL_BIT = DUR_LSB + DUR_W;

  state_t            state, state_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic [AW-1:0]     last_q, last_nxt;
  logic [DUR_W-1:0]  dur_cnt, dur_nxt;
  logic [LOOP_W-1:0] passes, passes_nxt;
  logic              level, level_nxt;
  logic              out_nxt, done_nxt, run_out;
  logic              load, tick, accept;
  logic [DUR_W:0]    sym;
  logic [DUR_W:0]    sym_mem [SYM_DEPTH];

`ifdef PULSE_TX_CARRIER_EN
  logic [7:0] car_cnt, car_cnt_nxt;
  logic       car_ph, car_ph_nxt;
`endif

  // Symbol table is deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (wr_en) sym_mem[wr_addr] <= wr_data;
  end

  assign accept = (state == S_IDLE) && start && !stop;

  pulse_tx_prescaler u_prescaler (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clear     (accept),
    .enable    (state == S_RUN),
    .prescale  (prescale),
    .tick      (tick)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    last_nxt   = last_q;
    dur_nxt    = dur_cnt;
    passes_nxt = passes;
    level_nxt  = level;
    done_nxt   = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt  = S_RUN;
          last_nxt   = last_idx;
          passes_nxt = loop_count;
          idx_nxt    = '0;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (dur_cnt != '0) begin
            dur_nxt = dur_cnt - 1'b1;
          end else if (idx != last_q) begin
            idx_nxt = idx + 1'b1;
            load    = 1'b1;
          end else if (passes != '0) begin
            passes_nxt = passes - 1'b1;
            idx_nxt    = '0;
            load       = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Slot is read at load time, so table writes land on the next visit.
    sym = sym_mem[idx_nxt];
    if (load) begin
      level_nxt = sym[LVL_BIT];
      dur_nxt   = sym[DUR_LSB +: DUR_W];
    end

`ifdef PULSE_TX_CARRIER_EN
    car_cnt_nxt = car_cnt;
    car_ph_nxt  = car_ph;
    if (load) begin
      car_cnt_nxt = carrier_div;
      car_ph_nxt  = 1'b1;
    end else if (state == S_RUN) begin
      if (car_cnt == '0) begin
        car_cnt_nxt = carrier_div;
        car_ph_nxt  = !car_ph;
      end else begin
        car_cnt_nxt = car_cnt - 1'b1;
      end
    end
    run_out = level_nxt & car_ph_nxt;
`else
    run_out = level_nxt;
`endif

    out_nxt = (state_nxt == S_RUN) ? run_out : idle_level;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      last_q     <= '0;
      dur_cnt    <= '0;
      passes     <= '0;
      level      <= 1'b0;
      pulse_out  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      last_q     <= last_nxt;
      dur_cnt    <= dur_nxt;
      passes     <= passes_nxt;
      level      <= level_nxt;
      pulse_out  <= out_nxt;
      done_pulse <= done_nxt;
    end
  end

`ifdef PULSE_TX_CARRIER_EN
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      car_cnt <= '0;
      car_ph  <= 1'b0;
    end else begin
      car_cnt <= car_cnt_nxt;
      car_ph  <= car_ph_nxt;
    end
  end
`endif

  assign busy = (state == S_RUN);

endmodule

// File: tb/tb_pulse_tx_sequencer.sv
// Bench for pulse_tx_sequencer: vector table, directed corner cases, and random runs
// checked against a waveform model built from the symbol table contents.
module tb_pulse_tx_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = 7;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] last_idx = '0;
  logic [7:0]    loop_count = '0;
  logic [3:0]    prescale = '0;
  logic          idle_level = 1'b0;
`ifdef PULSE_TX_CARRIER_EN
  logic [7:0]    carrier_div = 8'd255;
`endif
  logic          pulse_out, busy, done_pulse;

  int checks = 0;
  int errors = 0;
  logic [DW:0] ref_mem [DEPTH];

  typedef struct {
    bit start;
    bit stop;
    bit idle;
    bit out;
    bit busy;
    bit done;
  } vec_t;
  vec_t vt [12];

  always #5 clk = ~clk;

  pulse_tx_sequencer dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .stop        (stop),
    .last_idx    (last_idx),
    .loop_count  (loop_count),
    .prescale    (prescale),
    .idle_level  (idle_level),
`ifdef PULSE_TX_CARRIER_EN
    .carrier_div (carrier_div),
`endif
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done_pulse  (done_pulse)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input int a, input bit lvl, input int dur);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = {lvl, dur[DW-1:0]};
    ref_mem[a] = {lvl, dur[DW-1:0]};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected waveform: each symbol lasts (dur+1)*(pre+1) cycles, passes repeat the slot list.
  task automatic run_model(input int last, input int loops, input int pre, input bit idle,
                           input bit scramble);
    bit exp_q[$];
    int cd;
`ifdef PULSE_TX_CARRIER_EN
    cd = int'(carrier_div);
`else
    cd = -1;
`endif
    for (int p = 0; p <= loops; p++) begin
      for (int s = 0; s <= last; s++) begin
        bit lvl = ref_mem[s][DW];
        int n = (int'(ref_mem[s][DW-1:0]) + 1) * (pre + 1);
        for (int k = 0; k < n; k++) begin
          if (cd < 0) exp_q.push_back(lvl);
          else        exp_q.push_back(lvl && ((k / (cd + 1)) % 2 == 0));
        end
      end
    end
    idle_level = idle;
    last_idx   = last[AW-1:0];
    loop_count = loops[7:0];
    prescale   = pre[3:0];
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("run_out", int'(pulse_out), int'(exp_q[i]));
      chk("run_busy", int'(busy), 1);
      chk("run_done", int'(done_pulse), 0);
      if (scramble) begin
        last_idx   = AW'($urandom);
        loop_count = 8'($urandom);
        prescale   = 4'($urandom);
      end
      @(negedge clk);
    end
    chk("end_done", int'(done_pulse), 1);
    chk("end_busy", int'(busy), 0);
    chk("end_out", int'(pulse_out), int'(idle));
    @(negedge clk);
    chk("end_done_clear", int'(done_pulse), 0);
  endtask

  initial begin
    int at;
    int highs;

    for (int i = 0; i < 12; i++) vt[i] = '{0, 0, 0, 0, 1, 0};
    vt[0]  = '{1, 0, 0, 1, 1, 0};
    vt[1]  = '{0, 0, 0, 1, 1, 0};
    vt[2]  = '{0, 0, 0, 1, 1, 0};
    vt[3]  = '{0, 0, 0, 1, 1, 0};
    vt[4]  = '{0, 0, 0, 0, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 1, 0};
    vt[6]  = '{0, 0, 0, 1, 1, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 0, 1, 1, 0, 0};
    vt[10] = '{1, 1, 1, 1, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0};

    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_out", int'(pulse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_pulse), 0);
    @(negedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Three-symbol pass, then idle tracking and start+stop collision.
    wr(0, 1'b1, 3);
    wr(1, 1'b0, 1);
    wr(2, 1'b1, 0);
    last_idx = 3'd2; loop_count = 8'd0; prescale = 4'd0;
    for (int i = 0; i < 12; i++) begin
      start = vt[i].start; stop = vt[i].stop; idle_level = vt[i].idle;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk($sformatf("vec%0d_out", i), int'(pulse_out), int'(vt[i].out));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), int'(done_pulse), int'(vt[i].done));
    end

    // Stop in symbol 1.
    idle_level = 1'b1; last_idx = 3'd2; loop_count = 8'd0; prescale = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("stop_pre_out", int'(pulse_out), 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_out", int'(pulse_out), 1);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done_pulse), 0);
    @(negedge clk);
    chk("stop_done_after", int'(done_pulse), 0);
    chk("stop_out_after", int'(pulse_out), 1);

    // Second start while busy must not restart the sequence.
    idle_level = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    at = -1;
    for (int i = 2; i < 30; i++) begin
      if (done_pulse && at < 0) at = i;
      @(negedge clk);
    end
    chk("restart_ignored_done_at", at, 7);

    // Single symbol, prescale 3, two extra passes.
    wr(0, 1'b1, 0);
    last_idx = 3'd0; loop_count = 8'd2; prescale = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    highs = 0;
    at = -1;
    for (int i = 0; i < 100 && at < 0; i++) begin
      if (done_pulse) at = i;
      else if (busy && pulse_out) highs++;
      if (at < 0) @(negedge clk);
    end
    chk("loop_high_cycles", highs, 12);
    chk("loop_done_at", at, 12);
    @(negedge clk);

    // Asynchronous reset in the middle of a long high symbol.
    wr(0, 1'b1, 20);
    last_idx = 3'd0; loop_count = 8'd0; prescale = 4'd0; idle_level = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_out", int'(pulse_out), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_out", int'(pulse_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done_pulse), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_after_done", int'(done_pulse), 0);
      chk("arst_after_busy", int'(busy), 0);
    end

    // Table survives reset: slot 0 {1,20}, slots 1..2 from earlier.
    run_model(2, 0, 0, 1'b1, 1'b0);

`ifdef PULSE_TX_CARRIER_EN
    begin
      bit car_exp [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
      carrier_div = 8'd1;
      wr(0, 1'b1, 7);
      last_idx = 3'd0; loop_count = 8'd0; prescale = 4'd0; idle_level = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("carrier%0d", i), int'(pulse_out), int'(car_exp[i]));
        @(negedge clk);
      end
      chk("carrier_done", int'(done_pulse), 1);
      @(negedge clk);
    end
`endif

    // Random tables and settings; configuration inputs wander during the run.
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, 1'($urandom), int'($urandom_range(5)));
`ifdef PULSE_TX_CARRIER_EN
      carrier_div = 8'($urandom_range(3));
`endif
      run_model(int'($urandom_range(7)), int'($urandom_range(2)), int'($urandom_range(3)),
                1'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
